// File: rtl/ping_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ping_pkg
// Shared definitions for the single-wire ultrasonic ranging emulator:
//   - ping_state_t : responder FSM state encoding
//   - PING_*       : default timing constants (cycles at 100 MHz)
// ---------------------------------------------------------------------------
package ping_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_HOLD    = 3'd3,
        ST_ECHO    = 3'd4,
        ST_TAIL    = 3'd5
    } ping_state_t;

    localparam int unsigned PING_CNT_W    = 32;
    localparam int unsigned PING_TRIG_MIN = 200;
    localparam int unsigned PING_TRIG_MAX = 2000;
    localparam int unsigned PING_HOLDOFF  = 75000;
    localparam int unsigned PING_ECHO_MIN = 11500;
    localparam int unsigned PING_ECHO_MAX = 1850000;
    localparam int unsigned PING_TAIL     = 20;

endpackage

// File: rtl/bit_sync_2ff.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bit_sync_2ff
// Two-flop synchronizer for a single asynchronous bit, reset value 0.
// Ports:
//   clk   in  1  destination clock
//   rst_n in  1  asynchronous active-low reset
//   d     in  1  asynchronous input
//   q     out 1  synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module bit_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ping_sensor_emu.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ping_sensor_emu
// Device-side responder for the single-wire ultrasonic ranging protocol.
// Watches the shared sig wire for a host trigger pulse, waits a fixed holdoff,
// then drives an echo pulse whose width is the programmed distance, followed
// by a short driven-low tail before releasing the wire.
//
// Ports:
//   clk              in     1      system clock
//   rst_n            in     1      asynchronous active-low reset
//   sig              inout  1      shared trigger/echo wire, Z unless driving
//   echo_len         in     CNT_W  requested echo width in cycles
//   echo_len_we      in     1      load echo_len into the shadow register
//   obstacle_present in     1      0: answer with ECHO_MAX (nothing in range)
//   busy             out    1      accepted trigger until wire release
//   echo_active      out    1      high exactly while sig is driven high
//   err_trig         out    1      one-cycle pulse on a rejected trigger
//   trig_count       out    16     accepted triggers, wraps silently
//   dbg_state        out    3      current FSM state (ping_state_t encoding)
//
// Constraints: HOLDOFF >= 2, TAIL >= 1, 1 <= ECHO_MIN <= ECHO_MAX.
// ---------------------------------------------------------------------------
module ping_sensor_emu
    import ping_pkg::*;
#(
    parameter int unsigned CNT_W    = PING_CNT_W,
    parameter int unsigned TRIG_MIN = PING_TRIG_MIN,
    parameter int unsigned TRIG_MAX = PING_TRIG_MAX,
    parameter int unsigned HOLDOFF  = PING_HOLDOFF,
    parameter int unsigned ECHO_MIN = PING_ECHO_MIN,
    parameter int unsigned ECHO_MAX = PING_ECHO_MAX,
    parameter int unsigned TAIL     = PING_TAIL
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire              sig,
    input  logic [CNT_W-1:0] echo_len,
    input  logic             echo_len_we,
    input  logic             obstacle_present,
    output logic             busy,
    output logic             echo_active,
    output logic             err_trig,
    output logic [15:0]      trig_count,
    output logic [2:0]       dbg_state
);

    localparam logic [CNT_W-1:0] TRIG_MIN_C = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0] TRIG_MAX_C = CNT_W'(TRIG_MAX);
    localparam logic [CNT_W-1:0] ECHO_MIN_C = CNT_W'(ECHO_MIN);
    localparam logic [CNT_W-1:0] ECHO_MAX_C = CNT_W'(ECHO_MAX);
    // The fall-detect cycle itself is the first holdoff cycle, and the HOLD
    // exit edge is the one that raises the echo, hence the "-2".
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF - 2);
    localparam logic [CNT_W-1:0] TAIL_LOAD  = CNT_W'(TAIL - 1);

    logic s;
    logic s_prev_q, s_prev_d;

    ping_state_t      state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;         // trigger high-width counter
    logic [CNT_W-1:0] cnt_q, cnt_d;           // shared HOLD/ECHO/TAIL down-counter
    logic [CNT_W-1:0] len_q, len_d;           // echo width latched at accept
    logic [CNT_W-1:0] shadow_q, shadow_d;     // programmed echo width
    logic [15:0]      trig_count_q, trig_count_d;
    logic             err_q, err_d;
    logic             oe_q, oe_d;
    logic             dat_q, dat_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] clamped;

    bit_sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig),
        .q     (s)
    );

    // Unsigned full-width clamp; zero lands on ECHO_MIN.
    always_comb begin
        clamped = shadow_q;
        if (shadow_q < ECHO_MIN_C) begin
            clamped = ECHO_MIN_C;
        end else if (shadow_q > ECHO_MAX_C) begin
            clamped = ECHO_MAX_C;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        trig_count_d = trig_count_q;
        err_d        = 1'b0;
        s_prev_d     = s;
        // The shadow always takes the new value; an accept in the same cycle
        // reads shadow_q and therefore still sees the old one.
        shadow_d     = echo_len_we ? echo_len : shadow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (s && !s_prev_q) begin
                    state_d = ST_TRIG_HI;
                    wcnt_d  = CNT_W'(1);
                end
            end
            ST_TRIG_HI: begin
                if (s) begin
                    if (wcnt_q == TRIG_MAX_C) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_LO;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else if (wcnt_q < TRIG_MIN_C) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    len_d        = obstacle_present ? clamped : ECHO_MAX_C;
                    trig_count_d = trig_count_q + 16'd1;
                    cnt_d        = HOLD_LOAD;
                    state_d      = ST_HOLD;
                end
            end
            ST_WAIT_LO: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = len_q - 1'b1;
                    state_d = ST_ECHO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ECHO: begin
                if (cnt_q == '0) begin
                    cnt_d   = TAIL_LOAD;
                    state_d = ST_TAIL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TAIL: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Wire controls are registered decodes of the next state so the pin
        // changes on the same edge as the FSM, with no path from s to sig.
        oe_d   = (state_d == ST_ECHO) || (state_d == ST_TAIL);
        dat_d  = (state_d == ST_ECHO);
        busy_d = (state_d == ST_HOLD) || (state_d == ST_ECHO) || (state_d == ST_TAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s_prev_q     <= 1'b0;
            wcnt_q       <= '0;
            cnt_q        <= '0;
            len_q        <= ECHO_MIN_C;
            shadow_q     <= ECHO_MIN_C;
            trig_count_q <= '0;
            err_q        <= 1'b0;
            oe_q         <= 1'b0;
            dat_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_prev_q     <= s_prev_d;
            wcnt_q       <= wcnt_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            shadow_q     <= shadow_d;
            trig_count_q <= trig_count_d;
            err_q        <= err_d;
            oe_q         <= oe_d;
            dat_q        <= dat_d;
            busy_q       <= busy_d;
        end
    end

    // oe_q clears asynchronously, so reset releases the wire immediately.
    assign sig         = oe_q ? dat_q : 1'bz;
    assign echo_active = dat_q;
    assign busy        = busy_q;
    assign err_trig    = err_q;
    assign trig_count  = trig_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ping_sensor_emu.sv
`timescale 1ns/1ps
module tb_ping_sensor_emu;
  import ping_pkg::*;

  localparam int TMIN  = 4;
  localparam int TMAX  = 20;
  localparam int HOLD  = 10;
  localparam int EMIN  = 8;
  localparam int EMAX  = 100;
  localparam int TAILC = 2;
  localparam int SETTLE = HOLD + EMAX + TAILC + 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT
  wire         sig;
  logic        host_oe = 1'b0;
  logic [31:0] echo_len = '0;
  logic        echo_len_we = 1'b0;
  logic        obstacle_present = 1'b1;
  logic        busy, echo_active, err_trig;
  logic [15:0] trig_count;
  logic [2:0]  dbg_state;

  assign sig = host_oe ? 1'b1 : 1'bz;
  pulldown (sig);

  ping_sensor_emu #(
    .CNT_W(32), .TRIG_MIN(TMIN), .TRIG_MAX(TMAX), .HOLDOFF(HOLD),
    .ECHO_MIN(EMIN), .ECHO_MAX(EMAX), .TAIL(TAILC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig(sig), .echo_len(echo_len),
    .echo_len_we(echo_len_we), .obstacle_present(obstacle_present),
    .busy(busy), .echo_active(echo_active), .err_trig(err_trig),
    .trig_count(trig_count), .dbg_state(dbg_state)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_start_q[$], exp_len_q[$], exp_err_q[$];
  logic [31:0] got_start_q[$], got_len_q[$], got_err_q[$];
  logic [31:0] model_shadow = 32'(EMIN);
  logic [15:0] model_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: echo runs, err pulses, wire level versus echo_active
  logic ea_prev = 1'b0;
  int   run_start = 0;
  int   run_len = 0;
  always @(negedge clk) begin
    if (echo_active && !ea_prev) begin
      run_start = cyc;
      run_len = 0;
    end
    if (echo_active) run_len++;
    if (!echo_active && ea_prev) begin
      got_start_q.push_back(32'(run_start));
      got_len_q.push_back(32'(run_len));
    end
    if (err_trig) got_err_q.push_back(32'(cyc));
    if (!host_oe) check("sig_vs_echo_active", {31'd0, sig}, {31'd0, echo_active});
    ea_prev = echo_active;
  end

  // reference model: outcome of one trigger from the protocol rules
  function automatic logic [31:0] model_len(input int w, input logic obst);
    if (w < TMIN || w > TMAX) return 32'd0;
    if (!obst) return 32'(EMAX);
    if (model_shadow < 32'(EMIN)) return 32'(EMIN);
    if (model_shadow > 32'(EMAX)) return 32'(EMAX);
    return model_shadow;
  endfunction

  // r: cycle of the host rise, k: cycle of the host fall; len 0 = rejected
  task automatic push_exp(input int r, input int k, input int w, input logic [31:0] len);
    if (len == 0) begin
      if (w > TMAX) exp_err_q.push_back(32'(r + 2 + TMAX + 1));
      else          exp_err_q.push_back(32'(k + 3));
    end else begin
      exp_start_q.push_back(32'(k + 2 + HOLD));
      exp_len_q.push_back(len);
      model_count = model_count + 16'd1;
    end
  endtask

  // driver tasks
  task automatic host_pulse(input int w, output int r, output int k);
    @(negedge clk);
    r = cyc;
    host_oe = 1'b1;
    repeat (w) @(negedge clk);
    host_oe = 1'b0;
    k = cyc;
  endtask

  task automatic write_len(input logic [31:0] v);
    @(negedge clk);
    echo_len = v;
    echo_len_we = 1'b1;
    @(negedge clk);
    echo_len_we = 1'b0;
    model_shadow = v;
  endtask

  task automatic settle_and_check(input string tag);
    logic [31:0] e;
    repeat (SETTLE) @(negedge clk);
    while (exp_start_q.size() > 0) begin
      e = exp_start_q.pop_front();
      check({tag, "_echo_present"}, 32'(got_start_q.size() > 0), 32'd1);
      if (got_start_q.size() > 0) begin
        check({tag, "_echo_start"}, got_start_q.pop_front(), e);
        check({tag, "_echo_len"}, got_len_q.pop_front(), exp_len_q.pop_front());
      end else begin
        void'(exp_len_q.pop_front());
      end
    end
    check({tag, "_echo_extra"}, 32'(got_start_q.size()), 32'd0);
    while (exp_err_q.size() > 0) begin
      e = exp_err_q.pop_front();
      check({tag, "_err_present"}, 32'(got_err_q.size() > 0), 32'd1);
      if (got_err_q.size() > 0) check({tag, "_err_cycle"}, got_err_q.pop_front(), e);
    end
    check({tag, "_err_extra"}, 32'(got_err_q.size()), 32'd0);
    check({tag, "_trig_count"}, {16'd0, trig_count}, {16'd0, model_count});
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    got_start_q.delete(); got_len_q.delete(); got_err_q.delete();
  endtask

  typedef struct {
    int          w;
    logic        obst;
    logic        do_we;
    logic [31:0] len;
    logic [31:0] exp_len;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int r, k, w;
    logic obst;
    logic [31:0] v;

    vecs[0]  = '{10, 1'b1, 1'b0, 32'd0,          32'd8};
    vecs[1]  = '{10, 1'b1, 1'b1, 32'd50,         32'd50};
    vecs[2]  = '{2,  1'b1, 1'b0, 32'd0,          32'd0};
    vecs[3]  = '{25, 1'b1, 1'b0, 32'd0,          32'd0};
    vecs[4]  = '{10, 1'b1, 1'b1, 32'd3,          32'd8};
    vecs[5]  = '{10, 1'b1, 1'b1, 32'd500,        32'd100};
    vecs[6]  = '{10, 1'b0, 1'b1, 32'd50,         32'd100};
    vecs[7]  = '{4,  1'b1, 1'b0, 32'd0,          32'd50};
    vecs[8]  = '{3,  1'b1, 1'b0, 32'd0,          32'd0};
    vecs[9]  = '{20, 1'b1, 1'b0, 32'd0,          32'd50};
    vecs[10] = '{21, 1'b1, 1'b0, 32'd0,          32'd0};
    vecs[11] = '{1,  1'b1, 1'b0, 32'd0,          32'd0};
    vecs[12] = '{40, 1'b1, 1'b0, 32'd0,          32'd0};
    vecs[13] = '{10, 1'b1, 1'b1, 32'd0,          32'd8};
    vecs[14] = '{10, 1'b1, 1'b1, 32'd8,          32'd8};
    vecs[15] = '{10, 1'b1, 1'b1, 32'd9,          32'd9};
    vecs[16] = '{10, 1'b1, 1'b1, 32'd100,        32'd100};
    vecs[17] = '{10, 1'b1, 1'b1, 32'd101,        32'd100};
    vecs[18] = '{10, 1'b1, 1'b1, 32'hFFFF_FFFF,  32'd100};
    vecs[19] = '{10, 1'b1, 1'b1, 32'h8000_0064,  32'd100};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_echo_active", {31'd0, echo_active}, 32'd0);
    check("rst_err_trig", {31'd0, err_trig}, 32'd0);
    check("rst_trig_count", {16'd0, trig_count}, 32'd0);
    check("rst_sig", {31'd0, sig}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].do_we) write_len(vecs[i].len);
      obstacle_present = vecs[i].obst;
      host_pulse(vecs[i].w, r, k);
      push_exp(r, k, vecs[i].w, vecs[i].exp_len);
      settle_and_check($sformatf("vec%0d", i));
    end
    obstacle_present = 1'b1;

    // host activity during HOLD is ignored
    write_len(32'd50);
    host_pulse(10, r, k);
    push_exp(r, k, 10, 32'd50);
    repeat (3) @(negedge clk);
    host_pulse(5, r, w);
    settle_and_check("hold_ignore");

    // new length written mid-echo only affects the next trigger
    host_pulse(10, r, k);
    push_exp(r, k, 10, 32'd50);
    repeat (HOLD + 7) @(negedge clk);
    write_len(32'd70);
    settle_and_check("we_mid_echo");
    host_pulse(10, r, k);
    push_exp(r, k, 10, 32'd70);
    settle_and_check("we_next");

    // write coinciding with the accept edge: old shadow wins
    write_len(32'd50);
    host_pulse(10, r, k);
    @(negedge clk);
    @(negedge clk);
    echo_len = 32'd77;
    echo_len_we = 1'b1;
    push_exp(r, k, 10, 32'd50);
    @(negedge clk);
    echo_len_we = 1'b0;
    model_shadow = 32'd77;
    settle_and_check("we_at_accept");
    host_pulse(10, r, k);
    push_exp(r, k, 10, 32'd77);
    settle_and_check("we_after_accept");

    // asynchronous reset in the middle of an echo
    host_pulse(10, r, k);
    repeat (HOLD + 10) @(negedge clk);
    check("pre_reset_echo", {31'd0, echo_active}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sig", {31'd0, sig}, 32'd0);
    check("async_rst_echo", {31'd0, echo_active}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_count", {16'd0, trig_count}, 32'd0);
    repeat (3) @(negedge clk);
    exp_start_q.delete(); exp_len_q.delete(); exp_err_q.delete();
    got_start_q.delete(); got_len_q.delete(); got_err_q.delete();
    model_shadow = 32'(EMIN);
    model_count = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    host_pulse(10, r, k);
    push_exp(r, k, 10, 32'(EMIN));
    settle_and_check("post_reset");

    // randomized transactions against the model
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 130));
        write_len(v);
      end
      w = $urandom_range(1, 26);
      obst = ($urandom_range(0, 3) != 0);
      obstacle_present = obst;
      host_pulse(w, r, k);
      push_exp(r, k, w, model_len(w, obst));
      settle_and_check($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
